bus_controller: RTL and testbench

- 68000 bus-cycle front end directly upstream of dram_controller on Mackerel-10.
- Decodes ADDR_IN/FC into chip selects and applies the boot-vector ROM overlay.
- Inserts wait states for ROM/IO and merges DTACK_DRAM into the CPU DTACK.
- Generates autovector VPA on interrupt acknowledge, and BERR on timeout or unmapped access.

---
 rtl/bus_controller_pkg.sv | 54 +++++
 rtl/bus_watchdog.sv | 38 +++
 rtl/bus_controller.sv | 210 +++++++++++++++++++++
 tb/tb_bus_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_controller_pkg.sv
// Shared definitions for the Mackerel-10 bus front end: memory map,
// default timing, FSM/region encodings and the address decoder.
package bus_controller_pkg;

  localparam int unsigned DEF_ROM_WAIT     = 2;
  localparam int unsigned DEF_IO_WAIT      = 4;
  localparam int unsigned DEF_BERR_TIMEOUT = 64;
  localparam int unsigned DEF_BOOT_CYCLES  = 8;

  localparam logic [23:0] DRAM_LIMIT   = 24'h7F_FFFF;
  localparam logic [23:0] ROM_BASE     = 24'hF0_0000;
  localparam logic [23:0] ROM_LIMIT    = 24'hF7_FFFF;
  localparam logic [23:0] IO_PAGE_BASE = 24'hFF_0000;
  localparam logic [23:0] OVERLAY_SIZE = 24'h00_0800;

  localparam logic [2:0]  FC_IACK      = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_FAULT
  } bus_state_e;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_DRAM,
    RG_ROM,
    RG_IO,
    RG_IACK
  } region_e;

  // Interrupt acknowledge wins over the address; the boot overlay only
  // redirects reads so early writes to low memory still reach DRAM.
  function automatic region_e decode_region(input logic [23:0] addr,
                                            input logic [2:0]  fc,
                                            input logic        rw,
                                            input logic        boot);
    region_e rg;
    rg = RG_NONE;
    if (fc == FC_IACK) begin
      rg = RG_IACK;
    end else if (addr <= DRAM_LIMIT) begin
      rg = (boot && rw && (addr < OVERLAY_SIZE)) ? RG_ROM : RG_DRAM;
    end else if ((addr >= ROM_BASE) && (addr <= ROM_LIMIT)) begin
      rg = RG_ROM;
    end else if (addr >= IO_PAGE_BASE) begin
      rg = RG_IO;
    end
    return rg;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: counts enabled clocks and flags the clock on which
// the count reaches TIMEOUT. Saturates so a stuck strobe cannot wrap it.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear dominates, otherwise count up to saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = !clear_i && enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_controller.sv
// 68000 bus-cycle front end: region decode with boot overlay, wait-state
// insertion, DRAM DTACK merge, autovectored IACK and bus-error watchdog.
module bus_controller
  import bus_controller_pkg::*;
#(
  parameter int unsigned ROM_WAIT     = DEF_ROM_WAIT,
  parameter int unsigned IO_WAIT      = DEF_IO_WAIT,
  parameter int unsigned BERR_TIMEOUT = DEF_BERR_TIMEOUT,
  parameter int unsigned BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [2:0]  FC,
  input  logic [23:0] ADDR_IN,
  input  logic        DTACK_DRAM,
  output logic        CS_DRAM,
  output logic        CS_ROM,
  output logic        CS_IO,
  output logic        DTACK,
  output logic        VPA,
  output logic        BERR,
  output logic        BOOT
);

  localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);

  bus_state_e       state_q, state_d;
  region_e          region_q, region_d;
  region_e          dec_region;
  logic [7:0]       wait_q, wait_d;
  logic             cs_dram_q, cs_dram_d;
  logic             cs_rom_q, cs_rom_d;
  logic             cs_io_q, cs_io_d;
  logic             dtack_q, dtack_d;
  logic             vpa_q, vpa_d;
  logic             berr_q, berr_d;
  logic             as_q;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic             boot;
  logic             dtack;
  logic             wd_enable;
  logic             wd_expired;
  logic             release_all;
  logic             timed_region;
  logic             unused_strobes;

  // Byte strobes play no part in decode; address-only cycles ack normally.
  assign unused_strobes = UDS ^ LDS;

  assign boot         = (boot_cnt_q != BOOT_W'(BOOT_CYCLES));
  assign dec_region   = decode_region(ADDR_IN, FC, RW, boot);
  assign timed_region = (region_q == RG_ROM) || (region_q == RG_IO);

  // While a DRAM cycle waits, the DRAM acknowledge passes straight through;
  // once registered it is held by dtack_q until the strobe ends.
  assign dtack = dtack_q &
                 (((state_q == ST_WAIT) && (region_q == RG_DRAM)) ? DTACK_DRAM : 1'b1);

  assign wd_enable = !AS && dtack && vpa_q && (state_q != ST_FAULT);

  bus_watchdog #(
    .TIMEOUT(BERR_TIMEOUT)
  ) u_watchdog (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .clear_i  (AS),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  // Bus-cycle FSM: next state and registered strobe outputs.
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    wait_d      = wait_q;
    cs_dram_d   = cs_dram_q;
    cs_rom_d    = cs_rom_q;
    cs_io_d     = cs_io_q;
    dtack_d     = dtack_q;
    vpa_d       = vpa_q;
    berr_d      = berr_q;
    release_all = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!AS) begin
          region_d  = dec_region;
          cs_dram_d = (dec_region != RG_DRAM);
          cs_rom_d  = (dec_region != RG_ROM);
          cs_io_d   = (dec_region != RG_IO);
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (AS) begin
          release_all = 1'b1;
        end else if (wd_expired && (region_q != RG_IACK)) begin
          berr_d    = 1'b0;
          cs_dram_d = 1'b1;
          cs_rom_d  = 1'b1;
          cs_io_d   = 1'b1;
          state_d   = ST_FAULT;
        end else begin
          unique case (region_q)
            RG_IACK: begin
              vpa_d   = 1'b0;
              state_d = ST_ACK;
            end
            RG_ROM: begin
              wait_d  = 8'(ROM_WAIT);
              state_d = ST_WAIT;
            end
            RG_IO: begin
              wait_d  = 8'(IO_WAIT);
              state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
          endcase
        end
      end
      ST_WAIT: begin
        // Acknowledges are tested before the timeout so a same-clock ack wins.
        if (AS) begin
          release_all = 1'b1;
        end else if ((region_q == RG_DRAM) && !DTACK_DRAM) begin
          dtack_d = 1'b0;
          state_d = ST_ACK;
        end else if (timed_region && (wait_q <= 8'd1)) begin
          dtack_d = 1'b0;
          state_d = ST_ACK;
        end else if (wd_expired) begin
          berr_d    = 1'b0;
          cs_dram_d = 1'b1;
          cs_rom_d  = 1'b1;
          cs_io_d   = 1'b1;
          state_d   = ST_FAULT;
        end else if (timed_region) begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_ACK: begin
        if (AS) release_all = 1'b1;
      end
      ST_FAULT: begin
        if (AS) release_all = 1'b1;
      end
      default: release_all = 1'b1;
    endcase

    if (release_all) begin
      state_d   = ST_IDLE;
      cs_dram_d = 1'b1;
      cs_rom_d  = 1'b1;
      cs_io_d   = 1'b1;
      dtack_d   = 1'b1;
      vpa_d     = 1'b1;
      berr_d    = 1'b1;
    end
  end

  // Boot counter: one step per AS rising edge, saturating at BOOT_CYCLES.
  always_comb begin
    boot_cnt_d = boot_cnt_q;
    if (!as_q && AS && boot) begin
      boot_cnt_d = boot_cnt_q + BOOT_W'(1);
    end
  end

  // State, strobe and boot registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      region_q   <= RG_NONE;
      wait_q     <= '0;
      cs_dram_q  <= 1'b1;
      cs_rom_q   <= 1'b1;
      cs_io_q    <= 1'b1;
      dtack_q    <= 1'b1;
      vpa_q      <= 1'b1;
      berr_q     <= 1'b1;
      as_q       <= 1'b1;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      wait_q     <= wait_d;
      cs_dram_q  <= cs_dram_d;
      cs_rom_q   <= cs_rom_d;
      cs_io_q    <= cs_io_d;
      dtack_q    <= dtack_d;
      vpa_q      <= vpa_d;
      berr_q     <= berr_d;
      as_q       <= AS;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  assign CS_DRAM = cs_dram_q;
  assign CS_ROM  = cs_rom_q;
  assign CS_IO   = cs_io_q;
  assign DTACK   = dtack;
  assign VPA     = vpa_q;
  assign BERR    = berr_q;
  assign BOOT    = boot;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: directed and random bus cycles compared
// clock by clock against a cycle-outcome model of the bus front end.
module tb_bus_controller;

  localparam int unsigned ROM_WAIT     = 2;
  localparam int unsigned IO_WAIT      = 4;
  localparam int unsigned BERR_TIMEOUT = 64;
  localparam int unsigned BOOT_CYCLES  = 8;

  localparam int R_NONE = 0;
  localparam int R_DRAM = 1;
  localparam int R_ROM  = 2;
  localparam int R_IO   = 3;
  localparam int R_IACK = 4;

  logic        CLK = 1'b0;
  logic        RST, AS, UDS, LDS, RW, DTACK_DRAM;
  logic [2:0]  FC;
  logic [23:0] ADDR_IN;
  logic        CS_DRAM, CS_ROM, CS_IO, DTACK, VPA, BERR, BOOT;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned done_cycles = 0;
  int unsigned cyc_no = 0;

  bus_controller #(
    .ROM_WAIT    (ROM_WAIT),
    .IO_WAIT     (IO_WAIT),
    .BERR_TIMEOUT(BERR_TIMEOUT),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .AS        (AS),
    .UDS       (UDS),
    .LDS       (LDS),
    .RW        (RW),
    .FC        (FC),
    .ADDR_IN   (ADDR_IN),
    .DTACK_DRAM(DTACK_DRAM),
    .CS_DRAM   (CS_DRAM),
    .CS_ROM    (CS_ROM),
    .CS_IO     (CS_IO),
    .DTACK     (DTACK),
    .VPA       (VPA),
    .BERR      (BERR),
    .BOOT      (BOOT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
    end
  endtask

  // Output vector order: CS_DRAM CS_ROM CS_IO DTACK VPA BERR BOOT.
  function automatic logic [31:0] outs();
    return {25'd0, CS_DRAM, CS_ROM, CS_IO, DTACK, VPA, BERR, BOOT};
  endfunction

  function automatic logic [31:0] vec(input bit csd, input bit csr, input bit csi,
                                      input bit dtk, input bit vpa, input bit berr,
                                      input bit boot);
    return {25'd0, csd, csr, csi, dtk, vpa, berr, boot};
  endfunction

  // Memory map and overlay rule, by plain address ranges.
  function automatic int ref_region(input int unsigned a, input int unsigned fc,
                                    input bit rw, input bit boot);
    if (fc == 7) return R_IACK;
    if (a < 32'h80_0000) return (boot && rw && a < 32'h800) ? R_ROM : R_DRAM;
    if (a >= 32'hF0_0000 && a < 32'hF8_0000) return R_ROM;
    if (a >= 32'hFF_0000) return R_IO;
    return R_NONE;
  endfunction

  // One bus cycle. lat: DRAM stub asserts DTACK_DRAM after the lat-th clock
  // following the first AS-low edge; extra: clocks AS stays low after ack;
  // abort: AS released before any acknowledge.
  task automatic bus_cycle(input logic [23:0] addr, input logic [2:0] fc, input bit rw,
                           input int unsigned lat, input int unsigned extra, input bit abort);
    bit          boot;
    int          rg;
    int unsigned t, limit, hold;
    bit          fault, fl;
    string       tag;
    boot  = (done_cycles < BOOT_CYCLES);
    rg    = ref_region(32'(addr), 32'(fc), rw, boot);
    case (rg)
      R_DRAM:  t = 1 + lat;
      R_ROM:   t = 2 + ROM_WAIT;
      R_IO:    t = 2 + IO_WAIT;
      R_IACK:  t = 2;
      default: t = 100000;
    endcase
    fault = (rg != R_IACK) && (t >= BERR_TIMEOUT);
    limit = fault ? BERR_TIMEOUT : t;
    hold  = abort ? $urandom_range(limit - 1, 1) : limit + extra;
    cyc_no++;

    @(negedge CLK);
    ADDR_IN = addr;
    FC      = fc;
    RW      = rw;
    UDS     = 1'($urandom_range(1, 0));
    LDS     = 1'($urandom_range(1, 0));
    AS      = 1'b0;
    for (int unsigned n = 1; n <= hold; n++) begin
      @(negedge CLK);
      DTACK_DRAM = (rg == R_DRAM && n >= 1 + lat) ? 1'b0 : 1'b1;
      #1;
      fl  = fault && (n >= BERR_TIMEOUT);
      tag = $sformatf("cyc%0d@%06h n=%0d", cyc_no, addr, n);
      check(tag, outs(),
            vec(!(rg == R_DRAM && !fl), !(rg == R_ROM && !fl), !(rg == R_IO && !fl),
                !(rg != R_IACK && !fault && n >= t), !(rg == R_IACK && n >= 2),
                !fl, boot));
    end
    AS         = 1'b1;
    DTACK_DRAM = 1'b1;
    @(negedge CLK);
    #1;
    done_cycles++;
    check($sformatf("cyc%0d release", cyc_no), outs(),
          vec(1, 1, 1, 1, 1, 1, done_cycles < BOOT_CYCLES));
    repeat ($urandom_range(1, 0)) @(negedge CLK);
  endtask

  task automatic random_cycle();
    int unsigned sel, lat;
    logic [23:0] a;
    logic [2:0]  fc;
    bit          ab;
    sel = $urandom_range(9, 0);
    lat = $urandom_range(6, 1);
    fc  = 3'($urandom_range(6, 1));
    ab  = ($urandom_range(7, 0) == 0);
    if (sel <= 3) begin
      a = 24'($urandom_range(32'h7F_FFFF, 0));
      if ($urandom_range(7, 0) == 0) lat = 62 + $urandom_range(1, 0);
    end else if (sel <= 5) begin
      a = 24'($urandom_range(32'hF7_FFFF, 32'hF0_0000));
    end else if (sel <= 7) begin
      a = 24'($urandom_range(32'hFF_FFFF, 32'hFF_0000));
    end else if (sel == 8) begin
      a  = 24'($urandom_range(32'hFF_FFFF, 0));
      fc = 3'd7;
    end else begin
      if ($urandom_range(1, 0) == 1) a = 24'($urandom_range(32'hEF_FFFF, 32'h80_0000));
      else                            a = 24'($urandom_range(32'hFE_FFFF, 32'hF8_0000));
    end
    if (fc != 3'd7) a[0] = 1'b0;
    bus_cycle(a, fc, 1'($urandom_range(1, 0)), lat, $urandom_range(2, 0), ab);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RST        = 1'b0;
    AS         = 1'b1;
    UDS        = 1'b1;
    LDS        = 1'b1;
    RW         = 1'b1;
    FC         = 3'd0;
    ADDR_IN    = '0;
    DTACK_DRAM = 1'b1;
    #12;
    check("reset", outs(), vec(1, 1, 1, 1, 1, 1, 1));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check("idle", outs(), vec(1, 1, 1, 1, 1, 1, 1));

    bus_cycle(24'h000000, 3'd6, 1'b1, 1,  1, 1'b0); // overlay read -> ROM
    bus_cycle(24'h120034, 3'd5, 1'b0, 3,  0, 1'b0); // boot-time write -> DRAM
    bus_cycle(24'hFF0010, 3'd5, 1'b1, 1,  0, 1'b0); // IO page
    bus_cycle(24'hA00000, 3'd5, 1'b1, 1,  1, 1'b0); // unmapped -> BERR
    bus_cycle(24'hFFFFF5, 3'd7, 1'b1, 1,  2, 1'b0); // IACK -> VPA
    bus_cycle(24'h0007FE, 3'd6, 1'b1, 2,  0, 1'b0); // last overlaid word
    bus_cycle(24'h000800, 3'd6, 1'b1, 2,  0, 1'b0); // first word past overlay
    bus_cycle(24'h000010, 3'd5, 1'b0, 62, 1, 1'b0); // ack and timeout same clock
    bus_cycle(24'h000004, 3'd6, 1'b1, 3,  1, 1'b0); // overlay gone -> DRAM
    bus_cycle(24'h200000, 3'd5, 1'b1, 5,  0, 1'b1); // aborted DRAM cycle
    bus_cycle(24'hF00100, 3'd6, 1'b1, 1,  0, 1'b1); // aborted ROM cycle

    for (int unsigned i = 0; i < 50; i++) random_cycle();

    // Reset pulsed in the middle of an interrupt acknowledge.
    @(negedge CLK);
    FC      = 3'd7;
    ADDR_IN = 24'hFFFFF5;
    AS      = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("iack before reset", outs(), vec(1, 1, 1, 1, 0, 1, 0));
    RST = 1'b0;
    #1;
    check("reset mid-iack", outs(), vec(1, 1, 1, 1, 1, 1, 1));
    AS = 1'b1;
    FC = 3'd0;
    @(negedge CLK);
    RST         = 1'b1;
    done_cycles = 0;
    @(negedge CLK);
    #1;
    check("idle after reset", outs(), vec(1, 1, 1, 1, 1, 1, 1));
    bus_cycle(24'h000000, 3'd6, 1'b1, 1, 0, 1'b0);  // overlay restored

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
